main_mem_if: RTL and testbench

//  Downstream stage of cache_controller: serves its block-refill reads and write-through word writes.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/main_mem_beat_asm.sv | 39 +++
 rtl/main_mem_if.sv | 169 ++++++++++++++++
 tb/tb_main_mem_if.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths and state encoding for the cache-to-memory interface.
package cache_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BLOCK_BITS  = 512;
  localparam int unsigned OFFSET_BITS = 6;
  localparam int unsigned BEAT_BITS   = 64;
  localparam int unsigned BEATS       = BLOCK_BITS / BEAT_BITS;
  localparam int unsigned BEAT_CNT_W  = $clog2(BEATS);

  typedef enum logic [2:0] {
    StIdle,
    StRdCmd,
    StRdData,
    StWrCmd,
    StWrAck,
    StDone
  } mem_if_state_t;

endpackage

// File: rtl/main_mem_beat_asm.sv
// Beat counter and block deserialiser: places each read beat into the refill block,
// lowest address first, and flags the final beat of the block.
module main_mem_beat_asm
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [BEAT_BITS-1:0]  beat_data,
  output logic [BLOCK_BITS-1:0] block,
  output logic                  last
);

  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic [BLOCK_BITS-1:0] block_q;

  assign last  = beat_valid && (beat_cnt_q == BEAT_CNT_W'(BEATS - 1));
  assign block = block_q;

  // Write the incoming beat into its slot; counter wraps after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      block_q    <= '0;
    end else if (clear) begin
      beat_cnt_q <= '0;
      block_q    <= '0;
    end else if (beat_valid) begin
      for (int i = 0; i < int'(BEATS); i++) begin
        if (beat_cnt_q == BEAT_CNT_W'(i)) begin
          block_q[i*BEAT_BITS +: BEAT_BITS] <= beat_data;
        end
      end
      beat_cnt_q <= last ? '0 : beat_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/main_mem_if.sv
// Main memory interface: turns cache refills into a block-read command plus BEATS read
// beats, and write-through words into a single write command. Returns a one-cycle ready.
// Optional watchdog: define MAIN_MEM_TIMEOUT_EN to abort a stuck transaction after
// TIMEOUT_CYCLES non-idle cycles and raise the sticky mem_err flag.
module main_mem_if
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     main_mem_addr,
  input  logic [31:0]           main_mem_data_out,
  input  logic                  main_mem_read_req,
  input  logic                  main_mem_write_req,
  output logic [BLOCK_BITS-1:0] main_mem_data_in,
  output logic                  main_mem_ready,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_write,
  output logic [ADDR_W-1:0]     mem_cmd_addr,
  output logic [31:0]           mem_cmd_wdata,
  input  logic                  mem_rvalid,
  input  logic [BEAT_BITS-1:0]  mem_rdata,
  input  logic                  mem_wack,
  output logic                  mem_err
);

  mem_if_state_t      state_q;
  logic               cmd_valid_q;
  logic               cmd_write_q;
  logic [ADDR_W-1:0]  cmd_addr_q;
  logic [31:0]        cmd_wdata_q;
  logic               ready_q;

  logic               timeout_hit;
  logic               beat_valid;
  logic               beat_last;
  logic               beat_clear;

  // Beats only count while a refill is waiting for data; strays elsewhere are dropped.
  assign beat_valid = mem_rvalid && (state_q == StRdData);
  // A refill that times out leaves an all-zero block behind.
  assign beat_clear = timeout_hit && ((state_q == StRdCmd) || (state_q == StRdData));

  main_mem_beat_asm u_beat_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (beat_clear),
    .beat_valid (beat_valid),
    .beat_data  (mem_rdata),
    .block      (main_mem_data_in),
    .last       (beat_last)
  );

`ifdef MAIN_MEM_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q;
  logic           err_q;

  assign timeout_hit = (state_q != StIdle) && (state_q != StDone) &&
                       (wd_q == WdW'(TIMEOUT_CYCLES - 1));
  assign mem_err     = err_q;

  // Watchdog: held at zero in idle, counts every cycle of an active transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_q == StIdle) begin
      wd_q <= '0;
    end else if (state_q != StDone) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  logic unused_cfg;
  assign unused_cfg = ^main_mem_addr[1:0];
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{main_mem_addr[1:0], TIMEOUT_CYCLES[0]};
`endif

  // Transaction FSM with registered command and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Write wins when both requests are present.
          if (main_mem_write_req) begin
            state_q     <= StWrCmd;
            cmd_valid_q <= 1'b1;
            cmd_write_q <= 1'b1;
            cmd_addr_q  <= {main_mem_addr[ADDR_W-1:2], 2'b00};
            cmd_wdata_q <= main_mem_data_out;
          end else if (main_mem_read_req) begin
            state_q     <= StRdCmd;
            cmd_valid_q <= 1'b1;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= {main_mem_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end
        end
        StRdCmd: begin
          if (mem_cmd_ready) begin
            state_q     <= StRdData;
            cmd_valid_q <= 1'b0;
          end
        end
        StWrCmd: begin
          if (mem_cmd_ready) begin
            state_q     <= StWrAck;
            cmd_valid_q <= 1'b0;
          end
        end
        StRdData: begin
          if (beat_last) begin
            state_q <= StDone;
            ready_q <= 1'b1;
          end
        end
        StWrAck: begin
          if (mem_wack) begin
            state_q <= StDone;
            ready_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      // Watchdog abort overrides whatever the transaction was waiting on.
      if (timeout_hit) begin
        state_q     <= StDone;
        ready_q     <= 1'b1;
        cmd_valid_q <= 1'b0;
      end
    end
  end

  assign mem_cmd_valid  = cmd_valid_q;
  assign mem_cmd_write  = cmd_write_q;
  assign mem_cmd_addr   = cmd_addr_q;
  assign mem_cmd_wdata  = cmd_wdata_q;
  assign main_mem_ready = ready_q;

endmodule

// File: tb/tb_main_mem_if.sv
// Directed bench for main_mem_if: refill, write-through, backpressure, priority,
// reset mid-refill and watchdog behaviour.
module tb_main_mem_if;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  main_mem_addr;
  logic [31:0]  main_mem_data_out;
  logic         main_mem_read_req;
  logic         main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;
  logic         mem_cmd_valid;
  logic         mem_cmd_ready;
  logic         mem_cmd_write;
  logic [31:0]  mem_cmd_addr;
  logic [31:0]  mem_cmd_wdata;
  logic         mem_rvalid;
  logic [63:0]  mem_rdata;
  logic         mem_wack;
  logic         mem_err;

  int checks   = 0;
  int failures = 0;

  main_mem_if #(
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .main_mem_addr      (main_mem_addr),
    .main_mem_data_out  (main_mem_data_out),
    .main_mem_read_req  (main_mem_read_req),
    .main_mem_write_req (main_mem_write_req),
    .main_mem_data_in   (main_mem_data_in),
    .main_mem_ready     (main_mem_ready),
    .mem_cmd_valid      (mem_cmd_valid),
    .mem_cmd_ready      (mem_cmd_ready),
    .mem_cmd_write      (mem_cmd_write),
    .mem_cmd_addr       (mem_cmd_addr),
    .mem_cmd_wdata      (mem_cmd_wdata),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .mem_wack           (mem_wack),
    .mem_err            (mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_block(input logic [63:0] base);
    logic [511:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = base + 64'(i);
    return b;
  endfunction

  // Streams 8 beats base+i; counts ready pulses seen before the final beat completes.
  task automatic feed_beats(input logic [63:0] base, input bit gaps, output int early);
    early = 0;
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 64'(i);
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (i < 7 && main_mem_ready) early++;
      if (gaps && i < 7) begin
        tick();
        if (main_mem_ready) early++;
      end
    end
  endtask

  initial begin
    int early;
    int n;
    logic [511:0] blk1;

    rst_n = 1'b0;
    main_mem_addr = '0;
    main_mem_data_out = '0;
    main_mem_read_req = 1'b0;
    main_mem_write_req = 1'b0;
    mem_cmd_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    mem_wack = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_data_in", main_mem_data_in, '0);
    chk("rst_outs", {main_mem_ready, mem_cmd_valid, mem_cmd_write, mem_err}, 4'b0000);
    chk("rst_cmd", {mem_cmd_addr, mem_cmd_wdata}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: plain refill at 0x1000
    main_mem_read_req = 1'b1;
    main_mem_addr = 32'h0000_1000;
    mem_cmd_ready = 1'b1;
    tick();
    chk("t1_cmd", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr}, {1'b1, 1'b0, 32'h1000});
    tick();
    mem_cmd_ready = 1'b0;
    chk("t1_valid_drop", mem_cmd_valid, 1'b0);
    feed_beats(64'h40, 1'b0, early);
    chk("t1_early_ready", early, 0);
    chk("t1_ready", main_mem_ready, 1'b1);
    blk1 = mk_block(64'h40);
    chk("t1_block", main_mem_data_in, blk1);
    main_mem_read_req = 1'b0;
    tick();
    chk("t1_ready_pulse", main_mem_ready, 1'b0);

    // 2: write-through, delayed ack, inputs change after launch
    main_mem_write_req = 1'b1;
    main_mem_addr = 32'h0000_2004;
    main_mem_data_out = 32'hCAFE_BABE;
    tick();
    chk("t2_cmd", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata},
        {1'b1, 1'b1, 32'h2004, 32'hCAFE_BABE});
    main_mem_addr = 32'hFFFF_FFFF;
    main_mem_data_out = 32'h0;
    tick();
    chk("t2_cmd_hold", {mem_cmd_valid, mem_cmd_addr, mem_cmd_wdata},
        {1'b1, 32'h2004, 32'hCAFE_BABE});
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    chk("t2_valid_drop", mem_cmd_valid, 1'b0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (main_mem_ready) n++;
    end
    chk("t2_no_ready_wo_ack", n, 0);
    mem_wack = 1'b1;
    tick();
    mem_wack = 1'b0;
    main_mem_write_req = 1'b0;
    chk("t2_ready", main_mem_ready, 1'b1);
    chk("t2_data_in_kept", main_mem_data_in, blk1);
    tick();
    chk("t2_ready_pulse", main_mem_ready, 1'b0);

    // 3: command backpressure and gapped beats
    main_mem_read_req = 1'b1;
    main_mem_addr = 32'h0000_5024;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_cmd_stable", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr},
          {1'b1, 1'b0, 32'h5000});
    end
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    feed_beats(64'h5500_0000_0000_0000, 1'b1, early);
    chk("t3_early_ready", early, 0);
    chk("t3_ready", main_mem_ready, 1'b1);
    chk("t3_block", main_mem_data_in, mk_block(64'h5500_0000_0000_0000));
    main_mem_read_req = 1'b0;
    tick();
    // Stray beat and ack while idle
    mem_rvalid = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    mem_wack = 1'b1;
    tick(); tick();
    mem_rvalid = 1'b0;
    mem_wack = 1'b0;
    chk("t3_stray", {main_mem_ready, mem_cmd_valid}, 2'b00);
    chk("t3_stray_block", main_mem_data_in, mk_block(64'h5500_0000_0000_0000));

    // 4: simultaneous requests, write first, read only after re-assert
    main_mem_read_req = 1'b1;
    main_mem_write_req = 1'b1;
    main_mem_addr = 32'h0000_3000;
    main_mem_data_out = 32'h1234_5678;
    mem_cmd_ready = 1'b1;
    tick();
    chk("t4_write_first", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata},
        {1'b1, 1'b1, 32'h3000, 32'h1234_5678});
    tick();
    mem_wack = 1'b1;
    tick();
    mem_wack = 1'b0;
    chk("t4_wr_ready", main_mem_ready, 1'b1);
    main_mem_read_req = 1'b0;
    main_mem_write_req = 1'b0;
    tick(); tick();
    chk("t4_no_relaunch", {mem_cmd_valid, main_mem_ready}, 2'b00);
    main_mem_read_req = 1'b1;
    tick();
    chk("t4_read_cmd", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr}, {1'b1, 1'b0, 32'h3000});
    tick();
    mem_cmd_ready = 1'b0;
    feed_beats(64'h3300, 1'b0, early);
    chk("t4_rd_ready", {main_mem_ready, early[0]}, 2'b10);
    chk("t4_block", main_mem_data_in, mk_block(64'h3300));
    main_mem_read_req = 1'b0;
    tick();

    // 5: reset after the third beat of a refill
    main_mem_read_req = 1'b1;
    main_mem_addr = 32'h0000_4000;
    mem_cmd_ready = 1'b1;
    tick();
    tick();
    mem_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 64'h9900 + 64'(i);
      tick();
    end
    mem_rdata = 64'h9903;
    #2 rst_n = 1'b0;
    main_mem_read_req = 1'b0;
    #1;
    chk("t5_rst_block", main_mem_data_in, '0);
    chk("t5_rst_outs", {main_mem_ready, mem_cmd_valid, mem_cmd_write, mem_cmd_addr},
        {1'b0, 1'b0, 1'b0, 32'h0});
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    mem_rvalid = 1'b0;
    chk("t5_inflight_ignored", main_mem_data_in, '0);
    chk("t5_idle", {main_mem_ready, mem_cmd_valid, mem_err}, 3'b000);
    main_mem_read_req = 1'b1;
    mem_cmd_ready = 1'b1;
    tick();
    chk("t5_cmd", {mem_cmd_valid, mem_cmd_addr}, {1'b1, 32'h4000});
    tick();
    mem_cmd_ready = 1'b0;
    feed_beats(64'h4400, 1'b0, early);
    chk("t5_ready", {main_mem_ready, early[0]}, 2'b10);
    chk("t5_block", main_mem_data_in, mk_block(64'h4400));
    main_mem_read_req = 1'b0;
    tick();

    // 6: write never acknowledged
    main_mem_write_req = 1'b1;
    main_mem_addr = 32'h0000_6000;
    main_mem_data_out = 32'h0BAD_F00D;
    mem_cmd_ready = 1'b1;
    tick();
    chk("t6_cmd", {mem_cmd_valid, mem_cmd_write}, 2'b11);
    n = 0;
    early = 0;
    for (int i = 0; i < 40; i++) begin
      if (early == 0) begin
        tick();
        n++;
        if (main_mem_ready) begin
          early = 1;
          main_mem_write_req = 1'b0;
        end
      end
    end
`ifdef MAIN_MEM_TIMEOUT_EN
    chk("t6_timeout_seen", early, 1);
    chk("t6_timeout_cycle", n, 20);
    chk("t6_err", mem_err, 1'b1);
    tick();
    chk("t6_ready_pulse", main_mem_ready, 1'b0);
    tick(); tick();
    chk("t6_err_sticky", mem_err, 1'b1);
`else
    chk("t6_no_ready", early, 0);
    chk("t6_no_err", mem_err, 1'b0);
    main_mem_write_req = 1'b0;
`endif
    mem_cmd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_err_reset", {mem_err, main_mem_ready, mem_cmd_valid}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
